// File: rtl/axi_lite_vec_pkg.sv
// Shared types for the AXI-Lite vector replay master: FSM states, vector
// opcodes, AXI response codes and the fetched-vector record.
package axi_lite_vec_pkg;

  localparam int VEC_ADDR_W = 32;
  localparam int VEC_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_AW_W,
    ST_WAIT_B,
    ST_AR,
    ST_WAIT_R,
    ST_NEXT,
    ST_DONE
  } state_e;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    op_e                   op;
    logic [VEC_ADDR_W-1:0] addr;
    logic [VEC_DATA_W-1:0] data;
    logic                  last;
  } vector_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axi_lite_vector_master_if.sv
// AXI-Lite bus between the vector replay master and the slave under test.
interface axi_lite_vector_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   aw_addr;
  logic                aw_valid;
  logic                aw_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_valid;
  logic                w_ready;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;
  logic [ADDR_W-1:0]   ar_addr;
  logic                ar_valid;
  logic                ar_ready;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_valid;
  logic                r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi_lite_vector_master.sv
// Replays a ROM of write / read-compare vectors over AXI-Lite, one transaction
// at a time, and reports pass/fail, error count and the first failing vector.
module axi_lite_vector_master
  import axi_lite_vec_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = VEC_ADDR_W,
  parameter int AXI_DATA_WIDTH = VEC_DATA_W,
  parameter int VEC_DEPTH      = 256,
  parameter int TIMEOUT        = 1024,
  localparam int IDX_W         = $clog2(VEC_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [15:0]               err_count,
  output logic [IDX_W-1:0]          first_err_idx,
  output logic [IDX_W-1:0]          vec_idx,
  input  logic                      vec_op,
  input  logic [AXI_ADDR_WIDTH-1:0] vec_addr,
  input  logic [AXI_DATA_WIDTH-1:0] vec_data,
  input  logic                      vec_last,
  axi_lite_vector_master_if.master  axi
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  typedef logic [TMO_W-1:0] tmo_t;
  localparam tmo_t TMO_LAST = tmo_t'(TIMEOUT - 1);

  state_e                    state;
  tmo_t                      tmo_cnt;
  logic [AXI_DATA_WIDTH-1:0] exp_data;
  logic                      cur_last;
  vector_t                   fetched;
  logic                      waiting;
  logic                      complete;
  logic                      tmo_abort;
  logic                      log_err;

  assign axi.w_strb = '1;

  always_comb begin
    fetched.op   = op_e'(vec_op);
    fetched.addr = VEC_ADDR_W'(vec_addr);
    fetched.data = VEC_DATA_W'(vec_data);
    fetched.last = vec_last;
  end

  // Each wait state has a single "finished" condition; the timeout only fires
  // when that condition is still false on the last allowed cycle.
  always_comb begin
    waiting  = 1'b0;
    complete = 1'b0;
    log_err  = 1'b0;
    case (state)
      ST_AW_W: begin
        waiting  = 1'b1;
        complete = (!axi.aw_valid || axi.aw_ready) && (!axi.w_valid || axi.w_ready);
      end
      ST_WAIT_B: begin
        waiting  = 1'b1;
        complete = axi.b_valid;
        log_err  = axi.b_valid && (axi.b_resp != RESP_OKAY);
      end
      ST_AR: begin
        waiting  = 1'b1;
        complete = axi.ar_ready;
      end
      ST_WAIT_R: begin
        waiting  = 1'b1;
        complete = axi.r_valid;
        log_err  = axi.r_valid && ((axi.r_resp != RESP_OKAY) || (axi.r_data != exp_data));
      end
      default: ;
    endcase
    tmo_abort = waiting && !complete && (tmo_cnt == TMO_LAST);
    log_err   = log_err || tmo_abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= 16'd0;
      first_err_idx <= '0;
      vec_idx       <= '0;
      tmo_cnt       <= '0;
      exp_data      <= '0;
      cur_last      <= 1'b0;
      axi.aw_addr   <= '0;
      axi.aw_valid  <= 1'b0;
      axi.w_data    <= '0;
      axi.w_valid   <= 1'b0;
      axi.b_ready   <= 1'b0;
      axi.ar_addr   <= '0;
      axi.ar_valid  <= 1'b0;
      axi.r_ready   <= 1'b0;
    end else begin
      if (waiting) tmo_cnt <= complete ? '0 : tmo_cnt + tmo_t'(1);

      if (tmo_abort) begin
        axi.aw_valid <= 1'b0;
        axi.w_valid  <= 1'b0;
        axi.b_ready  <= 1'b0;
        axi.ar_valid <= 1'b0;
        axi.r_ready  <= 1'b0;
        timeout      <= 1'b1;
        state        <= ST_DONE;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= 16'd0;
            first_err_idx <= '0;
            vec_idx       <= '0;
            state         <= ST_FETCH;
          end
          // The ROM answers vec_idx one cycle later, so its outputs are valid here.
          ST_FETCH: begin
            exp_data <= AXI_DATA_WIDTH'(fetched.data);
            cur_last <= fetched.last;
            tmo_cnt  <= '0;
            if (fetched.op == OP_READ) begin
              axi.ar_addr  <= AXI_ADDR_WIDTH'(fetched.addr);
              axi.ar_valid <= 1'b1;
              state        <= ST_AR;
            end else begin
              axi.aw_addr  <= AXI_ADDR_WIDTH'(fetched.addr);
              axi.w_data   <= AXI_DATA_WIDTH'(fetched.data);
              axi.aw_valid <= 1'b1;
              axi.w_valid  <= 1'b1;
              state        <= ST_AW_W;
            end
          end
          ST_AW_W: begin
            if (axi.aw_ready) axi.aw_valid <= 1'b0;
            if (axi.w_ready)  axi.w_valid  <= 1'b0;
            if (complete) begin
              axi.b_ready <= 1'b1;
              state       <= ST_WAIT_B;
            end
          end
          ST_WAIT_B: if (axi.b_valid) begin
            axi.b_ready <= 1'b0;
            state       <= ST_NEXT;
          end
          ST_AR: if (axi.ar_ready) begin
            axi.ar_valid <= 1'b0;
            axi.r_ready  <= 1'b1;
            state        <= ST_WAIT_R;
          end
          ST_WAIT_R: if (axi.r_valid) begin
            axi.r_ready <= 1'b0;
            state       <= ST_NEXT;
          end
          ST_NEXT: begin
            if (cur_last || (vec_idx == IDX_W'(VEC_DEPTH - 1))) begin
              state <= ST_DONE;
            end else begin
              vec_idx <= vec_idx + IDX_W'(1);
              state   <= ST_FETCH;
            end
          end
          ST_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_count == 16'd0) && !timeout;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end

      // Counter never returns to zero once bumped, so zero means "no error yet".
      if (log_err) begin
        err_count <= sat_inc16(err_count);
        if (err_count == 16'd0) first_err_idx <= vec_idx;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_vector_master.sv
// Self-checking bench: vector ROM plus an AXI-Lite register-file slave with
// programmable ready delays and responses, serviced once per falling edge.
module tb_axi_lite_vector_master;
  import axi_lite_vec_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } vec_s;

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy, done, pass, timeout;
  logic [15:0]      err_count;
  logic [IDX_W-1:0] first_err_idx, vec_idx;
  logic             vec_op, vec_last;
  logic [AW-1:0]    vec_addr;
  logic [DW-1:0]    vec_data;

  logic          rom_op   [DEPTH];
  logic [AW-1:0] rom_addr [DEPTH];
  logic [DW-1:0] rom_data [DEPTH];
  logic          rom_last [DEPTH];

  always #5 clk = ~clk;

  axi_lite_vector_master_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  // Combinational read of the registered vec_idx gives the one-cycle ROM latency.
  assign vec_op   = rom_op[vec_idx];
  assign vec_addr = rom_addr[vec_idx];
  assign vec_data = rom_data[vec_idx];
  assign vec_last = rom_last[vec_idx];

  axi_lite_vector_master #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .VEC_DEPTH(DEPTH), .TIMEOUT(1024)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_idx(first_err_idx), .vec_idx(vec_idx),
    .vec_op(vec_op), .vec_addr(vec_addr), .vec_data(vec_data), .vec_last(vec_last),
    .axi(axi)
  );

  int   tests_run = 0;
  int   tests_failed = 0;
  txn_t sb_q[$];
  vec_s stim_q[$];

  int  aw_dly[2], w_dly[2];
  bit  b_enable, r_enable;
  int  b_err_write, r_bad_read;
  int  aw_wait, w_wait, ar_wait;
  bit  aw_hs, w_hs, ar_hs, b_hs, r_hs, have_aw, have_w;
  bit  prev_aw_pend, prev_w_pend, prev_ar_pend;
  logic [31:0] cap_aw, cap_w, cap_ar, prev_aw_addr, prev_w_data, prev_ar_addr;
  logic [3:0]  cap_strb;
  int  n_writes, n_reads, n_aw, n_w, hold_viol;
  logic [31:0] regs [logic [31:0]];

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic resetSlave(input int aw0, input int w0, input int aw1, input int w1,
                            input bit b_en, input bit r_en, input int b_err, input int r_bad);
    aw_dly[0] = aw0; w_dly[0] = w0; aw_dly[1] = aw1; w_dly[1] = w1;
    b_enable = b_en; r_enable = r_en; b_err_write = b_err; r_bad_read = r_bad;
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0; have_aw = 0; have_w = 0;
    prev_aw_pend = 0; prev_w_pend = 0; prev_ar_pend = 0;
    n_writes = 0; n_reads = 0; n_aw = 0; n_w = 0; hold_viol = 0;
    axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
    axi.b_valid = 0; axi.b_resp = RESP_OKAY;
    axi.r_valid = 0; axi.r_resp = RESP_OKAY; axi.r_data = '0;
    sb_q.delete();
    stim_q.delete();
  endtask

  task automatic slaveTick();
    int          dsel;
    txn_t        e;
    logic [31:0] rd;
    dsel = (n_writes == 0) ? 0 : 1;
    if (prev_aw_pend && (!axi.aw_valid || axi.aw_addr !== prev_aw_addr)) hold_viol++;
    if (prev_w_pend  && (!axi.w_valid  || axi.w_data  !== prev_w_data))  hold_viol++;
    if (prev_ar_pend && (!axi.ar_valid || axi.ar_addr !== prev_ar_addr)) hold_viol++;
    if (b_hs) begin axi.b_valid = 0; axi.b_resp = RESP_OKAY; b_hs = 0; end
    if (r_hs) begin axi.r_valid = 0; axi.r_data = '0; r_hs = 0; end

    if (aw_hs) begin axi.aw_ready = 0; aw_hs = 0; end
    else if (axi.aw_valid) begin
      if (!axi.aw_ready) begin
        if (aw_wait >= aw_dly[dsel]) axi.aw_ready = 1; else aw_wait++;
      end
      if (axi.aw_ready) begin aw_hs = 1; aw_wait = 0; have_aw = 1; cap_aw = axi.aw_addr; n_aw++; end
    end
    if (w_hs) begin axi.w_ready = 0; w_hs = 0; end
    else if (axi.w_valid) begin
      if (!axi.w_ready) begin
        if (w_wait >= w_dly[dsel]) axi.w_ready = 1; else w_wait++;
      end
      if (axi.w_ready) begin
        w_hs = 1; w_wait = 0; have_w = 1; cap_w = axi.w_data; cap_strb = axi.w_strb; n_w++;
      end
    end

    // A write is committed once both beats have been accepted.
    if (have_aw && have_w && !aw_hs && !w_hs) begin
      checkOutput("sb_nonempty_wr", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checkOutput("wr_op_addr", {31'd0, 1'b0, cap_aw}, {31'd0, e.op, e.addr});
        checkOutput("wr_data", 64'(cap_w), 64'(e.data));
        checkOutput("wr_strb", 64'(cap_strb), 64'hF);
      end
      regs[cap_aw] = cap_w;
      have_aw = 0; have_w = 0;
      if (b_enable) begin
        axi.b_valid = 1;
        axi.b_resp  = (n_writes == b_err_write) ? RESP_SLVERR : RESP_OKAY;
      end
      n_writes++;
    end

    if (ar_hs) begin
      axi.ar_ready = 0; ar_hs = 0;
      checkOutput("sb_nonempty_rd", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checkOutput("rd_op_addr", {31'd0, 1'b1, cap_ar}, {31'd0, e.op, e.addr});
      end
      if (r_enable) begin
        rd = regs.exists(cap_ar) ? regs[cap_ar] : 32'd0;
        if (n_reads == r_bad_read) rd = rd + 32'd1;
        axi.r_data = rd; axi.r_resp = RESP_OKAY; axi.r_valid = 1;
      end
      n_reads++;
    end else if (axi.ar_valid) begin
      if (!axi.ar_ready) begin
        if (ar_wait >= 0) axi.ar_ready = 1; else ar_wait++;
      end
      if (axi.ar_ready) begin ar_hs = 1; ar_wait = 0; cap_ar = axi.ar_addr; end
    end

    if (axi.b_valid && axi.b_ready) b_hs = 1;
    if (axi.r_valid && axi.r_ready) r_hs = 1;
    prev_aw_pend = axi.aw_valid && !axi.aw_ready; prev_aw_addr = axi.aw_addr;
    prev_w_pend  = axi.w_valid  && !axi.w_ready;  prev_w_data  = axi.w_data;
    prev_ar_pend = axi.ar_valid && !axi.ar_ready; prev_ar_addr = axi.ar_addr;
  endtask

  task automatic tick();
    @(negedge clk);
    slaveTick();
  endtask

  task automatic addVec(input logic op, input logic [31:0] addr, input logic [31:0] data, input logic last);
    vec_s v;
    v.op = op; v.addr = addr; v.data = data; v.last = last;
    stim_q.push_back(v);
  endtask

  task automatic applyStimulus(input bit dbl_start);
    txn_t t;
    for (int i = 0; i < DEPTH; i++) begin
      rom_op[i] = 1'b0; rom_addr[i] = '0; rom_data[i] = '0; rom_last[i] = 1'b1;
    end
    for (int i = 0; i < stim_q.size(); i++) begin
      rom_op[i] = stim_q[i].op; rom_addr[i] = stim_q[i].addr;
      rom_data[i] = stim_q[i].data; rom_last[i] = stim_q[i].last;
      t.op = stim_q[i].op; t.addr = stim_q[i].addr; t.data = stim_q[i].data;
      sb_q.push_back(t);
    end
    start = 1; tick(); start = 0;
    if (dbl_start) begin
      repeat (3) tick();
      start = 1; tick(); start = 0;
    end
  endtask

  task automatic waitDone(input string tag, input int limit, output int cycles);
    cycles = 0;
    while (!done && cycles < limit) begin
      tick();
      cycles++;
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    rst = 1; start = 0;
    resetSlave(0, 0, 0, 0, 1, 1, -1, -1);
    repeat (3) tick();
    checkOutput("rst_status", {60'd0, busy, done, pass, timeout}, 64'd0);
    checkOutput("rst_err_count", 64'(err_count), 64'd0);
    checkOutput("rst_idx", {48'd0, first_err_idx, vec_idx}, 64'd0);
    checkOutput("rst_bus", {59'd0, axi.aw_valid, axi.w_valid, axi.b_ready, axi.ar_valid, axi.r_ready}, 64'd0);
    rst = 0;
    tick();

    // Write then read back the same register with a zero-delay slave.
    resetSlave(0, 0, 0, 0, 1, 1, -1, -1);
    addVec(1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    addVec(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    applyStimulus(0);
    waitDone("t1", 50, cyc);
    checkOutput("t1_latency_le10", 64'(cyc <= 10), 64'd1);
    checkOutput("t1_pass", 64'(pass), 64'd1);
    checkOutput("t1_err_count", 64'(err_count), 64'd0);
    checkOutput("t1_sb_left", 64'(sb_q.size()), 64'd0);

    // Corrupted read data at vector 3; run still reaches the last vector.
    resetSlave(0, 0, 0, 0, 1, 1, -1, 1);
    addVec(1'b0, 32'hA0, 32'h11111111, 1'b0);
    addVec(1'b0, 32'hA4, 32'h12345678, 1'b0);
    addVec(1'b1, 32'hA0, 32'h11111111, 1'b0);
    addVec(1'b1, 32'hA4, 32'h12345678, 1'b0);
    addVec(1'b1, 32'hA0, 32'h11111111, 1'b1);
    applyStimulus(0);
    waitDone("t2", 100, cyc);
    checkOutput("t2_err_count", 64'(err_count), 64'd1);
    checkOutput("t2_first_err_idx", 64'(first_err_idx), 64'd3);
    checkOutput("t2_pass", 64'(pass), 64'd0);
    checkOutput("t2_vec_idx", 64'(vec_idx), 64'd4);
    checkOutput("t2_timeout", 64'(timeout), 64'd0);
    checkOutput("t2_sb_left", 64'(sb_q.size()), 64'd0);

    // Skewed aw/w readiness, plus a stray start pulse while busy.
    resetSlave(0, 5, 5, 0, 1, 1, -1, -1);
    addVec(1'b0, 32'h40, 32'hA5A5A5A5, 1'b0);
    addVec(1'b0, 32'h44, 32'h5A5A5A5A, 1'b0);
    addVec(1'b1, 32'h40, 32'hA5A5A5A5, 1'b0);
    addVec(1'b1, 32'h44, 32'h5A5A5A5A, 1'b1);
    applyStimulus(1);
    waitDone("t3", 200, cyc);
    checkOutput("t3_pass", 64'(pass), 64'd1);
    checkOutput("t3_err_count", 64'(err_count), 64'd0);
    checkOutput("t3_first_err_idx", 64'(first_err_idx), 64'd0);
    checkOutput("t3_aw_beats", 64'(n_aw), 64'd2);
    checkOutput("t3_w_beats", 64'(n_w), 64'd2);
    checkOutput("t3_hold_viol", 64'(hold_viol), 64'd0);
    checkOutput("t3_sb_left", 64'(sb_q.size()), 64'd0);

    // Slave never answers the write response.
    resetSlave(0, 0, 0, 0, 0, 1, -1, -1);
    addVec(1'b0, 32'h80, 32'hCAFEF00D, 1'b1);
    applyStimulus(0);
    waitDone("t4", 3000, cyc);
    checkOutput("t4_cycles_ge_1024", 64'(cyc >= 1024), 64'd1);
    checkOutput("t4_timeout", 64'(timeout), 64'd1);
    checkOutput("t4_pass", 64'(pass), 64'd0);
    checkOutput("t4_b_ready", 64'(axi.b_ready), 64'd0);
    checkOutput("t4_err_count", 64'(err_count), 64'd1);

    // SLVERR on vector 0 and no last flag: run stops at the final ROM slot.
    resetSlave(0, 0, 0, 0, 1, 1, 0, -1);
    for (int i = 0; i < DEPTH; i++) addVec(1'b0, 32'h1000 + 32'(i * 4), 32'(i) ^ 32'h5500AA00, 1'b0);
    applyStimulus(0);
    waitDone("t5", 3000, cyc);
    checkOutput("t5_err_count", 64'(err_count), 64'd1);
    checkOutput("t5_first_err_idx", 64'(first_err_idx), 64'd0);
    checkOutput("t5_vec_idx", 64'(vec_idx), 64'd255);
    checkOutput("t5_pass_timeout", {62'd0, pass, timeout}, 64'd0);
    checkOutput("t5_writes", 64'(n_writes), 64'd256);

    // Reset while waiting on read data, then a clean rerun.
    resetSlave(0, 0, 0, 0, 1, 0, -1, -1);
    addVec(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    applyStimulus(0);
    cyc = 0;
    while (!axi.r_ready && cyc < 50) begin tick(); cyc++; end
    checkOutput("t6_in_wait_r", 64'(axi.r_ready), 64'd1);
    rst = 1; start = 1;
    tick();
    checkOutput("t6_rst_status", {60'd0, busy, done, pass, timeout}, 64'd0);
    checkOutput("t6_rst_err_idx", {32'd0, err_count, first_err_idx, vec_idx}, 64'd0);
    checkOutput("t6_rst_bus", {59'd0, axi.aw_valid, axi.w_valid, axi.b_ready, axi.ar_valid, axi.r_ready}, 64'd0);
    rst = 0; start = 0;
    resetSlave(0, 0, 0, 0, 1, 1, -1, -1);
    tick();
    addVec(1'b0, 32'h10, 32'h0BADC0DE, 1'b0);
    addVec(1'b1, 32'h10, 32'h0BADC0DE, 1'b1);
    applyStimulus(0);
    waitDone("t6", 50, cyc);
    checkOutput("t6_pass", 64'(pass), 64'd1);
    checkOutput("t6_err_count", 64'(err_count), 64'd0);
    checkOutput("t6_sb_left", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
